// File: rtl/i281_mul_div_unit.sv
// rtl/i281_mul_div_unit.sv - sequential 8-bit unsigned multiply/divide unit for the i281 datapath
//
// Purpose:
//   Iterative shift-add multiplier and restoring divider sharing one
//   start/busy/done handshake. One iteration per clock, eight iterations
//   per operation, fixed latency of 8 cycles from the capture edge to DONE.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_start        request, sampled only in IDLE
//   i_op           0 = multiply, 1 = divide (sampled with i_start)
//   i_operand_a    multiplicand / dividend (register-file read port 0)
//   i_operand_b    multiplier / divisor   (register-file read port 1)
//   o_busy         high while iterating
//   o_done         one-cycle pulse, results valid from this cycle onward
//   o_result_lo    product[7:0] or quotient
//   o_result_hi    product[15:8] or remainder
//   o_overflow     multiply: product[15:8] != 0
//   o_div_by_zero  divide: captured divisor was zero
//   o_wb_strobe    register-file write request, identical to o_done

module i281_mul_div_unit (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_op,
    input  logic [7:0] i_operand_a,
    input  logic [7:0] i_operand_b,
    output logic       o_busy,
    output logic       o_done,
    output logic [7:0] o_result_lo,
    output logic [7:0] o_result_hi,
    output logic       o_overflow,
    output logic       o_div_by_zero,
    output logic       o_wb_strobe
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_op;
    logic [7:0]  r_opa;
    logic [7:0]  r_opb;
    logic [2:0]  r_count;
    logic [15:0] r_acc;     // multiply accumulator
    logic [8:0]  r_rem;     // divide partial remainder
    logic [7:0]  r_shift;   // multiplier (mul) or quotient (div) shift register
    logic        r_busy;
    logic        r_done;
    logic [7:0]  r_result_lo;
    logic [7:0]  r_result_hi;
    logic        r_overflow;
    logic        r_div_by_zero;

    // Multiply step: conditional add into the upper half with a 9-bit carry,
    // then shift {carry, accumulator} right by one.
    logic [8:0]  w_mul_sum;
    logic [15:0] w_acc_next;
    logic [7:0]  w_mpy_next;

    // Divide step: shift {remainder, quotient} left, trial-subtract divisor.
    // The extra MSB of w_div_diff is the borrow; set means "restore".
    logic [8:0]  w_rem_shift;
    logic [9:0]  w_div_diff;
    logic        w_div_ok;
    logic [8:0]  w_rem_next;
    logic [7:0]  w_quo_next;
    logic [7:0]  w_shift_next;

    always_comb begin
        w_mul_sum    = {1'b0, r_acc[15:8]} + (r_shift[0] ? {1'b0, r_opa} : 9'd0);
        w_acc_next   = {w_mul_sum, r_acc[7:1]};
        w_mpy_next   = {1'b0, r_shift[7:1]};

        w_rem_shift  = {r_rem[7:0], r_shift[7]};
        w_div_diff   = {1'b0, w_rem_shift} - {2'b00, r_opb};
        w_div_ok     = ~w_div_diff[9];
        w_rem_next   = w_div_ok ? w_div_diff[8:0] : w_rem_shift;
        w_quo_next   = {r_shift[6:0], w_div_ok};

        w_shift_next = r_op ? w_quo_next : w_mpy_next;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (i_start)         w_state_next = S_RUN;
            S_RUN:    if (r_count == 3'd7) w_state_next = S_FINISH;
            S_FINISH:                      w_state_next = S_IDLE;
            default:                       w_state_next = S_IDLE;
        endcase
    end

    // Datapath and registered outputs. Results are loaded on the edge that
    // performs the last iteration so they are valid in the FINISH cycle,
    // alongside the DONE pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op          <= 1'b0;
            r_opa         <= 8'h00;
            r_opb         <= 8'h00;
            r_count       <= 3'd0;
            r_acc         <= 16'h0000;
            r_rem         <= 9'h000;
            r_shift       <= 8'h00;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_result_lo   <= 8'h00;
            r_result_hi   <= 8'h00;
            r_overflow    <= 1'b0;
            r_div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_op          <= i_op;
                        r_opa         <= i_operand_a;
                        r_opb         <= i_operand_b;
                        r_count       <= 3'd0;
                        r_acc         <= 16'h0000;
                        r_rem         <= 9'h000;
                        // Multiply shifts the multiplier out; divide shifts
                        // the dividend out while the quotient shifts in.
                        r_shift       <= i_op ? i_operand_a : i_operand_b;
                        r_busy        <= 1'b1;
                        r_overflow    <= 1'b0;
                        r_div_by_zero <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_shift <= w_shift_next;
                    r_count <= r_count + 3'd1;
                    if (r_op) begin
                        r_rem <= w_rem_next;
                    end else begin
                        r_acc <= w_acc_next;
                    end
                    if (r_count == 3'd7) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                        if (r_op) begin
                            r_result_lo   <= w_quo_next;
                            r_result_hi   <= w_rem_next[7:0];
                            r_div_by_zero <= (r_opb == 8'h00);
                        end else begin
                            r_result_lo   <= w_acc_next[7:0];
                            r_result_hi   <= w_acc_next[15:8];
                            r_overflow    <= (w_acc_next[15:8] != 8'h00);
                        end
                    end
                end
                S_FINISH: begin
                    r_done <= 1'b0;
                end
                default: begin
                    r_busy <= 1'b0;
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_wb_strobe   = r_done;
    assign o_result_lo   = r_result_lo;
    assign o_result_hi   = r_result_hi;
    assign o_overflow    = r_overflow;
    assign o_div_by_zero = r_div_by_zero;

endmodule

// File: doc/i281_mul_div_unit.md
# i281_mul_div_unit

Sequential 8-bit unsigned multiply/divide unit for the i281 CPU datapath, directly downstream of the 4x8-bit register file. It consumes the two register-file read ports (port 0 = operand A, port 1 = operand B) and produces a 16-bit product or an 8-bit quotient/remainder pair. It also drives a one-cycle write-back strobe for the register-file write path. One iterative shift/add-subtract step runs per clock, under a start/busy/done handshake.

## Interface
Parameters: none. Width is fixed at 8 bits to match the register file.

- Clock  in  1  system clock; all state updates on rising edge
- Reset  in  1  asynchronous, active-low; clears all state immediately
- START  in  1  request; sampled only in IDLE
- OP  in  1  0 = multiply, 1 = divide; sampled with START
- OPERAND_A  in  8  multiplicand / dividend (register-file read port 0)
- OPERAND_B  in  8  multiplier / divisor (register-file read port 1)
- BUSY  out  1  high while iterating (RUN state)
- DONE  out  1  one-cycle pulse; results valid from this cycle onward
- RESULT_LO  out  8  product[7:0] or quotient
- RESULT_HI  out  8  product[15:8] or remainder
- OVERFLOW  out  1  multiply only: product[15:8] != 0
- DIV_BY_ZERO  out  1  divide only: OPERAND_B was 0x00
- WB_STROBE  out  1  equals DONE; write-enable request toward the register file

## Operation
- States: IDLE, RUN, FINISH. Reset state is IDLE.
- IDLE:
  - START=1 captures OPERAND_A, OPERAND_B and OP into internal registers.
  - Clears the iteration counter, enters RUN.
  - Clears OVERFLOW and DIV_BY_ZERO.
  - RESULT_HI/RESULT_LO are not cleared; they hold the previous result until FINISH.
- RUN: one iteration per clock; 3-bit counter 0..7; after the iteration with counter=7, enters FINISH.
- Multiply (shift-add):
  - 16-bit accumulator, 8-bit multiplier shift register.
  - Each step: if multiplier LSB=1, add multiplicand to accumulator upper half with a 9-bit carry.
  - Then shift the {carry, accumulator} pair right by 1 and shift the multiplier right by 1.
  - Result = A*B, exact 16 bits.
- Divide (restoring):
  - 9-bit partial remainder, 8-bit quotient shift register initialised to A.
  - Each step: shift {remainder, quotient} left by 1, then trial-subtract B.
  - If the difference is non-negative, keep it and set quotient LSB=1; otherwise restore and set LSB=0.
- Divide by zero is not special-cased in the datapath. The algorithm naturally yields quotient 0xFF and remainder = A. DIV_BY_ZERO is set from the captured B==0.
- FINISH:
  - Loads RESULT_HI/RESULT_LO and sets OVERFLOW (multiply) or DIV_BY_ZERO (divide).
  - DONE=WB_STROBE=1 for exactly one cycle, then returns to IDLE.
- START is ignored in RUN and FINISH; there is no queueing. A new START is accepted in the first IDLE cycle after FINISH.
- Operand inputs may change freely after capture; the in-flight operation is unaffected.
- All arithmetic is unsigned.

## Timing
- Reset low (any time, including mid-RUN):
  - State goes to IDLE asynchronously.
  - Counter, accumulator, RESULT_HI, RESULT_LO, OVERFLOW, DIV_BY_ZERO, BUSY, DONE and WB_STROBE all go to 0.
  - The in-flight operation is discarded with no DONE.
- Edge 0 (START=1 in IDLE): capture; BUSY=1 after this edge.
- Edges 1..8: eight iterations; BUSY stays high.
- After edge 8: state FINISH, BUSY=0, DONE=1, results valid.
- After edge 9: state IDLE, DONE=0, results held.
- Latency is fixed at 8 cycles from the capture edge to DONE, independent of operand values. Start-to-start throughput is 10 cycles.
- BUSY and DONE are never high in the same cycle.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Multiply 0x0F × 0x11 -> after 8 cycles, DONE pulse; RESULT_HI=0x00, RESULT_LO=0xFF, OVERFLOW=0, WB_STROBE co-incident with DONE.
- Multiply 0xFF × 0xFF -> RESULT_HI=0xFE, RESULT_LO=0x01, OVERFLOW=1.
- Divide 0xC8 (200) ÷ 0x07 -> RESULT_LO=0x1C, RESULT_HI=0x04, DIV_BY_ZERO=0.
- Divide 0x5A ÷ 0x00 -> RESULT_LO=0xFF, RESULT_HI=0x5A, DIV_BY_ZERO=1, latency still 8 cycles.
- START pulsed again 3 cycles into a multiply, with different operands and OP=1 -> ignored; the original product completes. A START in the cycle after DONE is accepted, and its result appears 8 cycles later.
- Reset asserted 4 cycles into a divide -> all outputs 0 immediately, no DONE. After release, multiply 0x03 × 0x04 gives RESULT_LO=0x0C, RESULT_HI=0x00.
